// File: rtl/hdb3_decoder.sv
// hdb3_decoder: recovers NRZ data from a dual-rail HDB3 line.
// Each mark is tested for a bipolar violation (V). A V zeroes the 4-deep
// shift register, so the V and the three positions before it (000V or B00V)
// come out as 0000. Output latency is four valid symbols.
// Optional build macro HDB3_ERR_CHECK_EN adds line-code error checking.
// An error is flagged for an illegal symbol (both rails high) or for a
// fourth zero in a row.
module hdb3_decoder (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_p,
    input  logic in_n,
    output logic data_out,
    output logic out_valid,
    output logic code_err
);

    localparam logic POL_P = 1'b1;
    localparam logic POL_N = 1'b0;

    logic [3:0] sr;
    logic       last_pol;
    logic       seen_mark;
    logic [2:0] fill;

    logic is_p;
    logic is_n;
    logic is_mark;
    logic is_v;

    // Symbol decode and violation detection for the symbol on the rails
    always_comb begin
        is_p    = in_p & ~in_n;
        is_n    = ~in_p & in_n;
        is_mark = is_p | is_n;
        is_v    = is_mark & seen_mark & ((is_p ? POL_P : POL_N) == last_pol);
    end

    // Shift register, data output and polarity history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= 4'b0000;
            data_out  <= 1'b0;
            last_pol  <= POL_N;
            seen_mark <= 1'b0;
        end else if (in_valid) begin
            data_out <= sr[3];
            if (is_v)
                sr <= 4'b0000;
            else
                sr <= {sr[2:0], is_mark};
            if (is_mark) begin
                last_pol  <= is_p ? POL_P : POL_N;
                seen_mark <= 1'b1;
            end
        end
    end

    // Pipeline fill tracking; out_valid uses the fill level before this symbol
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill      <= 3'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid && (fill == 3'd4);
            if (in_valid && (fill != 3'd4))
                fill <= fill + 3'd1;
        end
    end

`ifdef HDB3_ERR_CHECK_EN
    logic [2:0] zero_cnt;
    logic       is_zero;
    logic       is_illegal;

    // An illegal symbol counts as a zero for the run length
    always_comb begin
        is_zero    = ~is_mark;
        is_illegal = in_p & in_n;
    end

    // Run length of consecutive zeros; idle cycles do not break a run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            zero_cnt <= 3'd0;
        else if (in_valid) begin
            if (is_mark)
                zero_cnt <= 3'd0;
            else if (zero_cnt != 3'd7)
                zero_cnt <= zero_cnt + 3'd1;
        end
    end

    // Single registered pulse even when both error causes coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            code_err <= 1'b0;
        else
            code_err <= in_valid && (is_illegal || (is_zero && (zero_cnt == 3'd3)));
    end
`else
    assign code_err = 1'b0;
`endif

endmodule
